// File: rtl/stat_merge_pipe.sv
// Merges N_CH partial sum / sum-of-squares channels through a registered pairwise adder tree.
// An optional accumulator follows the tree. Define STAT_MERGE_OVF_EN to add the sticky ovf output.
module stat_merge_pipe #(
   parameter int N_CH = 5,
   parameter int W    = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N_CH*W-1:0] sum_in,
   input  logic [N_CH*W-1:0] sq_in,
   input  logic [N_CH-1:0]   ch_mask,
   input  logic              acc_mode,
   input  logic              acc_clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      sum_out,
   output logic [W-1:0]      sq_out,
   output logic [15:0]       set_cnt
`ifdef STAT_MERGE_OVF_EN
   ,
   output logic              ovf
`endif
);

   localparam int L   = $clog2(N_CH) + 1;
   localparam int LVL = L - 1;

   function automatic int lvl_cnt(input int l);
      return (N_CH + (1 << l) - 1) >> l;
   endfunction

   function automatic logic [W-1:0] mask_word(input logic [W-1:0] v, input logic en);
      return en ? v : '0;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   logic              stall;
   logic              clr_eff;
   logic              clr_pend;
   logic [LVL:1]      vld_p;
   logic [LVL:1]      mode_p;
   logic [W-1:0]      sum_p   [1:LVL][0:N_CH-1];
   logic [W-1:0]      sq_p    [1:LVL][0:N_CH-1];
   logic [W-1:0]      op_sum  [0:LVL-1][0:N_CH-1];
   logic [W-1:0]      op_sq   [0:LVL-1][0:N_CH-1];
   logic [W-1:0]      nxt_sum [1:LVL][0:N_CH-1];
   logic [W-1:0]      nxt_sq  [1:LVL][0:N_CH-1];
   logic [W-1:0]      tree_sum, tree_sq;
   logic [W-1:0]      acc_sum, acc_sq;
   logic [W-1:0]      acc_sum_nxt, acc_sq_nxt;
   logic [15:0]       acc_cnt;
`ifdef STAT_MERGE_OVF_EN
   logic [LVL-1:0]    op_ovf;
   logic [LVL:1]      ovf_p, nxt_ovf;
   logic              c_s, c_q, acc_c_s, acc_c_q;
`endif

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign clr_eff  = acc_clr || clr_pend;
   assign tree_sum = sum_p[LVL][0];
   assign tree_sq  = sq_p[LVL][0];

   // Tree operands: masked inputs feed level 0, registered levels feed the rest.
   // An odd trailing operand is carried to the next level unchanged.
   always_comb begin
      for (int l = 0; l < LVL; l++) begin
         for (int j = 0; j < N_CH; j++) begin
            op_sum[l][j] = '0;
            op_sq[l][j]  = '0;
         end
      end
      for (int j = 0; j < N_CH; j++) begin
         op_sum[0][j] = mask_word(sum_in[j*W +: W], ch_mask[j]);
         op_sq[0][j]  = mask_word(sq_in[j*W +: W], ch_mask[j]);
      end
      for (int l = 1; l < LVL; l++) begin
         for (int j = 0; j < N_CH; j++) begin
            op_sum[l][j] = sum_p[l][j];
            op_sq[l][j]  = sq_p[l][j];
         end
      end
`ifdef STAT_MERGE_OVF_EN
      c_s    = 1'b0;
      c_q    = 1'b0;
      op_ovf = '0;
      for (int l = 1; l < LVL; l++) op_ovf[l] = ovf_p[l];
`endif
      for (int l = 0; l < LVL; l++) begin
         for (int j = 0; j < N_CH; j++) begin
            nxt_sum[l+1][j] = '0;
            nxt_sq[l+1][j]  = '0;
         end
`ifdef STAT_MERGE_OVF_EN
         nxt_ovf[l+1] = op_ovf[l];
`endif
         for (int j = 0; j < N_CH/2; j++) begin
            if (2*j+1 < lvl_cnt(l)) begin
`ifdef STAT_MERGE_OVF_EN
               {c_s, nxt_sum[l+1][j]} = {1'b0, op_sum[l][2*j]} + {1'b0, op_sum[l][2*j+1]};
               {c_q, nxt_sq[l+1][j]}  = {1'b0, op_sq[l][2*j]} + {1'b0, op_sq[l][2*j+1]};
               nxt_ovf[l+1] = nxt_ovf[l+1] | c_s | c_q;
`else
               nxt_sum[l+1][j] = op_sum[l][2*j] + op_sum[l][2*j+1];
               nxt_sq[l+1][j]  = op_sq[l][2*j] + op_sq[l][2*j+1];
`endif
            end
         end
         if (lvl_cnt(l) % 2 == 1) begin
            nxt_sum[l+1][lvl_cnt(l)/2] = op_sum[l][lvl_cnt(l)-1];
            nxt_sq[l+1][lvl_cnt(l)/2]  = op_sq[l][lvl_cnt(l)-1];
         end
      end
   end

   always_comb begin
`ifdef STAT_MERGE_OVF_EN
      {acc_c_s, acc_sum_nxt} = {1'b0, acc_sum} + {1'b0, tree_sum};
      {acc_c_q, acc_sq_nxt}  = {1'b0, acc_sq} + {1'b0, tree_sq};
`else
      acc_sum_nxt = acc_sum + tree_sum;
      acc_sq_nxt  = acc_sq + tree_sq;
`endif
   end

   // Stage boundary: tree levels _p1.._pLVL
   always_ff @(posedge clk) begin
      if (!stall) begin
         for (int l = 1; l <= LVL; l++) begin
            for (int j = 0; j < N_CH; j++) begin
               sum_p[l][j] <= nxt_sum[l][j];
               sq_p[l][j]  <= nxt_sq[l][j];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p  <= '0;
         mode_p <= '0;
`ifdef STAT_MERGE_OVF_EN
         ovf_p  <= '0;
`endif
      end else if (!stall) begin
         vld_p  <= LVL'({vld_p, in_valid});
         mode_p <= LVL'({mode_p, acc_mode});
`ifdef STAT_MERGE_OVF_EN
         ovf_p  <= nxt_ovf;
`endif
      end
   end

   // Stage boundary: output / accumulate register; a clear seen while stalled waits in clr_pend
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         sum_out   <= '0;
         sq_out    <= '0;
         set_cnt   <= '0;
         acc_sum   <= '0;
         acc_sq    <= '0;
         acc_cnt   <= '0;
         clr_pend  <= 1'b0;
`ifdef STAT_MERGE_OVF_EN
         ovf       <= 1'b0;
`endif
      end else if (stall) begin
         if (acc_clr) clr_pend <= 1'b1;
      end else begin
         clr_pend  <= 1'b0;
         out_valid <= vld_p[LVL];
         if (vld_p[LVL] && mode_p[LVL]) begin
            if (clr_eff) begin
               acc_sum <= tree_sum;
               acc_sq  <= tree_sq;
               acc_cnt <= 16'd1;
               sum_out <= tree_sum;
               sq_out  <= tree_sq;
               set_cnt <= 16'd1;
            end else begin
               acc_sum <= acc_sum_nxt;
               acc_sq  <= acc_sq_nxt;
               acc_cnt <= sat_inc(acc_cnt);
               sum_out <= acc_sum_nxt;
               sq_out  <= acc_sq_nxt;
               set_cnt <= sat_inc(acc_cnt);
            end
         end else begin
            if (vld_p[LVL]) begin
               sum_out <= tree_sum;
               sq_out  <= tree_sq;
               set_cnt <= 16'd1;
            end else if (clr_eff) begin
               set_cnt <= 16'd0;
            end
            if (clr_eff) begin
               acc_sum <= '0;
               acc_sq  <= '0;
               acc_cnt <= '0;
            end
         end
`ifdef STAT_MERGE_OVF_EN
         if (clr_eff)
            ovf <= vld_p[LVL] && ovf_p[LVL];
         else
            ovf <= ovf || (vld_p[LVL] && (ovf_p[LVL] || (mode_p[LVL] && (acc_c_s || acc_c_q))));
`endif
      end
   end

endmodule

// File: doc/stat_merge_pipe.md
STAT_MERGE_PIPE -- requirements
Module: stat_merge_pipe

Interface
REQ-001 Parameter N_CH, default 5: number of partial-sum channels, legal range 2..16.
REQ-002 Parameter W, default 64: width of each sum and sum-of-squares word.
REQ-003 Derived constant L = clog2(N_CH) + 1: pipeline latency in cycles (5 channels gives L = 4).
REQ-004 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: a channel set is present on the inputs.
REQ-007 Port in_ready, output, 1 bit: the block accepts a channel set this cycle.
REQ-008 Port sum_in, input, N_CH*W bits: channel k sum at bits [k*W +: W].
REQ-009 Port sq_in, input, N_CH*W bits: channel k sum-of-squares at bits [k*W +: W].
REQ-010 Port ch_mask, input, N_CH bits: 1 includes the channel, 0 forces its contribution to 0; sampled with the set.
REQ-011 Port acc_mode, input, 1 bit: 0 = per-set output, 1 = running accumulation; sampled with the set.
REQ-012 Port acc_clr, input, 1 bit: single-cycle clear of the accumulator.
REQ-013 Port out_valid, output, 1 bit: result valid.
REQ-014 Port out_ready, input, 1 bit: downstream accepts the result.
REQ-015 Port sum_out, output, W bits: merged sum.
REQ-016 Port sq_out, output, W bits: merged sum-of-squares.
REQ-017 Port set_cnt, output, 16 bits: number of sets folded into the current accumulator.

Function
REQ-018 A set transfers when in_valid && in_ready; a result transfers when out_valid && out_ready.
REQ-019 Adder tree: pairwise, registered per level, clog2(N_CH) levels, plus one output/accumulate register stage.
- Odd operand at a level passes through to the next level, delayed one register.
REQ-020 A set accepted at cycle t produces out_valid at cycle t+L if no stall occurs.
REQ-021 Arithmetic is unsigned, modulo 2^W, with no saturation.
REQ-022 Masking is applied before the first tree level; mask all-zero yields 0/0.
REQ-023 Stall condition: out_valid && !out_ready freezes every pipeline register, including valid bits, mode bits and the accumulator.
REQ-024 in_ready = !(out_valid && !out_ready), combinational.
REQ-025 Per-set output (acc_mode = 0):
- sum_out/sq_out = masked tree sums.
- set_cnt = 1.
- Accumulator unchanged.
REQ-026 Accumulation (acc_mode = 1):
- Accumulator += tree sums.
- sum_out/sq_out = new accumulator value.
- set_cnt increments, saturating at 16'hFFFF.
REQ-027 acc_clr without a set at the output stage: accumulator and set_cnt become 0 next cycle; out_valid is unaffected.
REQ-028 acc_clr in the same cycle as an acc_mode = 1 set at the output stage: accumulator loads that set's sums only; set_cnt = 1.
REQ-029 acc_clr during a stall is held off: it takes effect on the first unstalled cycle.
REQ-030 Back-to-back sets with no stall sustain one result per cycle.
REQ-031 Results leave in acceptance order; no set is dropped or duplicated under any in_valid/out_ready pattern.

Reset
REQ-032 reset, sampled on the rising edge of clk, forces next cycle:
- all pipeline valid bits 0, out_valid 0
- sum_out, sq_out, accumulator 0
- set_cnt 0
REQ-033 In-flight sets are discarded on reset; in_ready is 1 on the first cycle after reset deasserts.
REQ-034 reset overrides acc_clr and a stall.

Configuration
REQ-035 Macro STAT_MERGE_OVF_EN is defined: add output port ovf, 1 bit, sticky.
- Set when any tree addition or accumulate carries out of W bits.
- Cleared only by reset or acc_clr.
- Asserts in the same cycle as the out_valid of the offending result.
REQ-036 Macro STAT_MERGE_OVF_EN is undefined: the ovf port and its carry logic are absent; all other behaviour is identical.

Verification
REQ-037 N_CH=5, mask 5'h1F, sums 1,2,3,4,5, squares 1,4,9,16,25, out_ready=1 -> 4 cycles later sum_out=15, sq_out=55, set_cnt=1.
REQ-038 Same set, ch_mask=5'b00101 -> sum_out=4, sq_out=10.
REQ-039 acc_mode=1, three sets each summing 15 -> sum_out 15, 30, 45 on consecutive cycles; set_cnt 1,2,3; then acc_clr with a fourth set -> sum_out=15, set_cnt=1.
REQ-040 out_ready=0 for 6 cycles during a 10-set stream -> in_ready low while out_valid is held; all 10 results emerge in order, with values stable while stalled.
REQ-041 Channel 0 sum = 2^W-1, channel 1 = 1 -> sum_out=0; with STAT_MERGE_OVF_EN, ovf=1 until acc_clr.
REQ-042 reset asserted with 3 sets in flight -> no out_valid afterward for those sets, all outputs 0, in_ready=1 after reset release.
